hcsr04_ranger: RTL and testbench



---
 rtl/hcsr04_ranger.sv | 273 +++++++++++++++++++++++++++
 tb/tb_hcsr04_ranger.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: HC-SR04 ultrasonic ranger sequencer.
// Issues trigger pulses, times the echo width in centimetre units using a
// prescaler (no divider), flags timeouts and drives a proximity alarm.
// Optional feature macro: HCSR04_BUZZER_EN. When it is defined, a 1 kHz-style
// tone is generated while near=1. Without it, buzzer_export is tied low.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for enable and (continuous or start)
// S_TRIG      | trigger high for TRIG_CYCLES clocks; period timer running
// S_WAIT_RISE | waiting for a synchronized low-to-high echo transition
// S_MEASURE   | counting echo width in cm until the falling edge
// S_HOLDOFF   | waiting out the trigger-to-trigger period
module hcsr04_ranger #(
    parameter int unsigned TRIG_CYCLES      = 500,
    parameter int unsigned CM_CYCLES        = 2900,
    parameter int unsigned TIMEOUT_CYCLES   = 1900000,
    parameter int unsigned PERIOD_CYCLES    = 3000000,
    parameter int unsigned BUZZ_HALF_CYCLES = 25000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       enable,
    input  logic       continuous,
    input  logic       start,
    input  logic [9:0] threshold_cm,
    output logic       hctrig_export,
    input  logic       hcecho_export,
    output logic [9:0] dist_cm,
    output logic       valid,
    output logic       timeout,
    output logic       busy,
    output logic       near,
    output logic       buzzer_export
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    localparam int TRIG_W = (TRIG_CYCLES > 1)    ? $clog2(TRIG_CYCLES)    : 1;
    localparam int PRE_W  = (CM_CYCLES > 1)      ? $clog2(CM_CYCLES)      : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PER_W  = (PERIOD_CYCLES > 1)  ? $clog2(PERIOD_CYCLES)  : 1;

    localparam logic [TRIG_W-1:0] TRIG_LOAD = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CM_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LOAD  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [9:0]        CM_MAX    = 10'd1023;

    // Reject parameter sets the sequencing cannot honour.
    if (CM_CYCLES < 2) begin : g_bad_cm
        $error("hcsr04_ranger: CM_CYCLES must be at least 2");
    end
    if (PERIOD_CYCLES <= TRIG_CYCLES + TIMEOUT_CYCLES) begin : g_bad_period
        $error("hcsr04_ranger: PERIOD_CYCLES must exceed TRIG_CYCLES + TIMEOUT_CYCLES");
    end
    if (BUZZ_HALF_CYCLES < 1) begin : g_bad_buzz
        $error("hcsr04_ranger: BUZZ_HALF_CYCLES must be at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [9:0]        cm_q, cm_d;
    logic [9:0]        dist_q, dist_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              good_q, good_d;
    logic              near_q, near_d;
    logic              trig_q, trig_d;
    logic              busy_q, busy_d;
    logic [2:0]        echo_sync_q, echo_sync_d;
    logic              echo_rise, echo_fall;
    logic              res_good, res_to;

    // [0] metastable stage, [1] synchronized echo, [2] previous synchronized echo.
    assign echo_rise = echo_sync_q[1] & ~echo_sync_q[2];
    assign echo_fall = ~echo_sync_q[1] & echo_sync_q[2];

    // Next-state, counter and result logic for the measurement sequence.
    always_comb begin
        state_d     = state_q;
        trig_cnt_d  = trig_cnt_q;
        per_cnt_d   = (per_cnt_q != '0) ? per_cnt_q - PER_W'(1) : per_cnt_q;
        to_cnt_d    = (to_cnt_q != '0) ? to_cnt_q - TO_W'(1) : to_cnt_q;
        pre_d       = pre_q;
        cm_d        = cm_q;
        dist_d      = dist_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        good_d      = good_q;
        res_good    = 1'b0;
        res_to      = 1'b0;
        echo_sync_d = {echo_sync_q[1:0], hcecho_export};

        case (state_q)
            S_IDLE: begin
                if (enable && (continuous || start)) begin
                    state_d    = S_TRIG;
                    trig_cnt_d = TRIG_LOAD;
                    per_cnt_d  = PER_LOAD;
                end
            end
            S_TRIG: begin
                if (trig_cnt_q == '0) begin
                    state_d  = S_WAIT_RISE;
                    to_cnt_d = TO_LOAD;
                end else begin
                    trig_cnt_d = trig_cnt_q - TRIG_W'(1);
                end
            end
            S_WAIT_RISE: begin
                if (to_cnt_q == '0) begin
                    res_to = 1'b1;
                end else if (echo_rise) begin
                    // The rise cycle itself is the first high clock of the echo.
                    state_d = S_MEASURE;
                    pre_d   = PRE_ONE;
                    cm_d    = '0;
                end
            end
            S_MEASURE: begin
                if (echo_fall) begin
                    res_good = 1'b1;
                end else if (to_cnt_q == '0) begin
                    res_to = 1'b1;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (cm_q != CM_MAX) begin
                        cm_d = cm_q + 10'd1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            S_HOLDOFF: begin
                if (per_cnt_q == '0) begin
                    if (enable && continuous) begin
                        state_d    = S_TRIG;
                        trig_cnt_d = TRIG_LOAD;
                        per_cnt_d  = PER_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (res_good) begin
            state_d   = S_HOLDOFF;
            dist_d    = cm_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            good_d    = 1'b1;
        end else if (res_to) begin
            state_d   = S_HOLDOFF;
            dist_d    = CM_MAX;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            good_d    = 1'b0;
        end

        // Disable aborts silently: previous result and flags are kept.
        if (!enable) begin
            state_d    = S_IDLE;
            trig_cnt_d = '0;
            per_cnt_d  = '0;
            to_cnt_d   = '0;
            pre_d      = '0;
            cm_d       = '0;
            dist_d     = dist_q;
            valid_d    = 1'b0;
            timeout_d  = timeout_q;
            good_d     = good_q;
        end
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        trig_d = (state_d == S_TRIG);
        busy_d = (state_d != S_IDLE);
        near_d = good_d & (dist_d < threshold_cm);
    end

    // State, counter and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            trig_cnt_q  <= '0;
            per_cnt_q   <= '0;
            to_cnt_q    <= '0;
            pre_q       <= '0;
            cm_q        <= '0;
            dist_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            good_q      <= 1'b0;
            near_q      <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            echo_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            trig_cnt_q  <= trig_cnt_d;
            per_cnt_q   <= per_cnt_d;
            to_cnt_q    <= to_cnt_d;
            pre_q       <= pre_d;
            cm_q        <= cm_d;
            dist_q      <= dist_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            good_q      <= good_d;
            near_q      <= near_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            echo_sync_q <= echo_sync_d;
        end
    end

    assign hctrig_export = trig_q;
    assign dist_cm       = dist_q;
    assign valid         = valid_q;
    assign timeout       = timeout_q;
    assign busy          = busy_q;
    assign near          = near_q;

`ifdef HCSR04_BUZZER_EN
    localparam int BUZZ_W = (BUZZ_HALF_CYCLES > 1) ? $clog2(BUZZ_HALF_CYCLES) : 1;
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_HALF_CYCLES - 1);

    logic [BUZZ_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              buzz_q, buzz_d;

    // Tone generator: toggles every BUZZ_HALF_CYCLES while near, silent and rearmed otherwise.
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        buzz_d     = buzz_q;
        if (!near_q) begin
            tone_cnt_d = BUZZ_LOAD;
            buzz_d     = 1'b0;
        end else if (tone_cnt_q == '0) begin
            tone_cnt_d = BUZZ_LOAD;
            buzz_d     = ~buzz_q;
        end else begin
            tone_cnt_d = tone_cnt_q - BUZZ_W'(1);
        end
    end

    // Tone registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tone_cnt_q <= BUZZ_LOAD;
            buzz_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            buzz_q     <= buzz_d;
        end
    end

    assign buzzer_export = buzz_q;
`else
    assign buzzer_export = 1'b0;
`endif

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger with shortened timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hcsr04_ranger;

    localparam int TRIG = 5;
    localparam int CM   = 4;
    localparam int TO   = 5000;
    localparam int PER  = 5300;
    localparam int BUZZ = 7;

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       enable        = 1'b0;
    logic       continuous    = 1'b0;
    logic       start         = 1'b0;
    logic       hcecho_export = 1'b0;
    logic [9:0] threshold_cm  = 10'd15;
    logic       hctrig_export, valid, timeout, busy, near, buzzer_export;
    logic [9:0] dist_cm;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int vcount  = 0;
    int buzz_hi = 0;
    int t0, tw, tv, tr, v0, n;

    hcsr04_ranger #(
        .TRIG_CYCLES     (TRIG),
        .CM_CYCLES       (CM),
        .TIMEOUT_CYCLES  (TO),
        .PERIOD_CYCLES   (PER),
        .BUZZ_HALF_CYCLES(BUZZ)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (enable),
        .continuous    (continuous),
        .start         (start),
        .threshold_cm  (threshold_cm),
        .hctrig_export (hctrig_export),
        .hcecho_export (hcecho_export),
        .dist_cm       (dist_cm),
        .valid         (valid),
        .timeout       (timeout),
        .busy          (busy),
        .near          (near),
        .buzzer_export (buzzer_export)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) begin
        if (valid === 1'b1) vcount++;
        if (buzzer_export !== 1'b0) buzz_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk_clk);
        cyc += k;
    endtask

    task automatic wait_trig(input logic lvl, input string tag);
        int i = 0;
        while (hctrig_export !== lvl && i < 20000) begin
            step(1);
            i++;
        end
        chk(tag, hctrig_export, lvl);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (valid !== 1'b1 && i < 20000) begin
            step(1);
            i++;
        end
        chk(tag, valid, 1);
    endtask

    task automatic echo_pulse(input int dly, input int width);
        step(dly);
        hcecho_export = 1'b1;
        step(width);
        hcecho_export = 1'b0;
    endtask

    task automatic fire();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic abort();
        enable = 1'b0;
        step(1);
        enable = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(3);
        chk("rst_trig", hctrig_export, 0);
        chk("rst_dist", dist_cm, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_near", near, 0);
        chk("rst_buzz", buzzer_export, 0);
        reset_reset_n = 1'b1;
        enable = 1'b1;
        step(2);

        // Single shot: echo 40 clocks wide -> 10 cm.
        fire();
        chk("trig_rise_latency", hctrig_export, 1);
        t0 = cyc;
        n = 0;
        while (hctrig_export === 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk("trig_width", n, TRIG);
        tw = cyc;
        echo_pulse(20, 40);
        wait_valid("valid_single");
        tv = cyc;
        chk("valid_latency", cyc - tw, 63);
        chk("single_dist", dist_cm, 10);
        chk("single_timeout", timeout, 0);
        chk("single_near", near, 1);
        step(1);
        chk("valid_one_cycle", valid, 0);
`ifdef HCSR04_BUZZER_EN
        n = 0;
        while (buzzer_export !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk("buzz_first", cyc - tv, BUZZ);
        tr = cyc;
        n = 0;
        while (buzzer_export !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        chk("buzz_half", cyc - tr, BUZZ);
`else
        step(2 * BUZZ);
        chk("buzz_tied_near", buzzer_export, 0);
`endif
        fire();
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            step(1);
            n++;
        end
        chk("busy_len", cyc - t0, PER);
        step(3);
        chk("start_not_queued", busy, 0);

        // No echo -> timeout result.
        fire();
        wait_trig(0, "trig_fall_noecho");
        tw = cyc;
        v0 = vcount;
        wait_valid("valid_noecho");
        chk("noecho_latency", cyc - tw, TO);
        chk("noecho_dist", dist_cm, 1023);
        chk("noecho_timeout", timeout, 1);
        chk("noecho_near", near, 0);
        step(2);
        chk("buzz_off", buzzer_export, 0);
        chk("noecho_one_valid", vcount - v0, 1);
        abort();
        chk("abort_idle", busy, 0);
        chk("abort_dist_hold", dist_cm, 1023);

        // Echo already high at trigger, falls while waiting: must still time out.
        hcecho_export = 1'b1;
        step(5);
        fire();
        wait_trig(0, "trig_fall_stuck");
        tw = cyc;
        step(100);
        hcecho_export = 1'b0;
        wait_valid("valid_stuck");
        chk("stuck_latency", cyc - tw, TO);
        chk("stuck_dist", dist_cm, 1023);
        chk("stuck_timeout", timeout, 1);
        abort();

        // Falling edge on the timeout terminal cycle: edge wins, 400 clocks -> 100 cm.
        fire();
        wait_trig(0, "trig_fall_tie");
        tw = cyc;
        echo_pulse(TO - 403, 400);
        wait_valid("valid_tie");
        chk("tie_latency", cyc - tw, TO);
        chk("tie_dist", dist_cm, 100);
        chk("tie_timeout_cleared", timeout, 0);
        chk("tie_near", near, 0);
        abort();

        // Very long echo saturates at 1023 but is still a good result.
        fire();
        wait_trig(0, "trig_fall_sat");
        echo_pulse(10, 4200);
        wait_valid("valid_sat");
        chk("sat_dist", dist_cm, 1023);
        chk("sat_timeout", timeout, 0);
        abort();

        // Continuous mode: widths 83 and 80 both give 20 cm.
        continuous = 1'b1;
        wait_trig(1, "cont_first");
        t0 = cyc;
        for (int p = 0; p < 2; p++) begin
            wait_trig(0, "cont_fall");
            echo_pulse(10, (p == 0) ? 83 : 80);
            wait_valid("cont_valid");
            chk("cont_dist", dist_cm, 20);
            wait_trig(1, "cont_next");
            chk("cont_period", cyc - t0, PER);
            t0 = cyc;
        end
        wait_trig(0, "cont_fall_abort");
        step(10);
        hcecho_export = 1'b1;
        step(30);
        v0 = vcount;
        enable = 1'b0;
        step(1);
        chk("mid_abort_busy", busy, 0);
        chk("mid_abort_trig", hctrig_export, 0);
        hcecho_export = 1'b0;
        continuous = 1'b0;
        enable = 1'b1;
        step(20);
        chk("mid_abort_no_valid", vcount - v0, 0);
        chk("mid_abort_dist", dist_cm, 20);

        // Asynchronous reset while the trigger is high.
        fire();
        step(2);
        chk("pre_reset_trig", hctrig_export, 1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk("arst_trig", hctrig_export, 0);
        chk("arst_dist", dist_cm, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", valid, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_near", near, 0);
        chk("arst_buzz", buzzer_export, 0);
        step(2);
        reset_reset_n = 1'b1;
        step(2);
`ifndef HCSR04_BUZZER_EN
        chk("buzz_never_high", buzz_hi, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
